// File: rtl/retime_token_sink.sv
// Elastic receive FIFO behind a retiming token stage.
// Registered Nack with hysteresis, slack reservation and sticky overflow.
module retime_token_sink #(
    parameter int WIDTH_DATA = 32,
    parameter int DEPTH      = 8,
    parameter int NACK_SLACK = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    I_Valid,
    input  logic [WIDTH_DATA-1:0]   I_Data,
    output logic                    O_Nack,
    output logic                    O_Valid,
    output logic [WIDTH_DATA-1:0]   O_Data,
    input  logic                    I_Ready,
    output logic [$clog2(DEPTH):0]  O_Count,
    output logic                    O_Empty,
    output logic                    O_Full,
    output logic                    O_Overflow,
    input  logic                    I_ClrErr
);

    localparam int AW = $clog2(DEPTH);
    localparam int HI = DEPTH - NACK_SLACK;
    localparam int LO = HI - 2;
    localparam logic [AW:0] C_HI = (AW+1)'(HI);
    localparam logic [AW:0] C_LO = (AW+1)'(LO);

    typedef enum logic {
        S_ACCEPT,
        S_HOLD
    } state_t;

    logic [WIDTH_DATA-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wp;
    logic [AW:0]           r_rp;
    state_t                r_state;
    logic                  r_nack;
    logic                  r_ovf;

    logic [AW:0]           w_count;
    logic [AW:0]           w_count_next;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_rd;
    state_t                w_state_next;

    assign w_count = r_wp - r_rp;
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) &&
                     (r_wp[AW] != r_rp[AW]);
    assign w_wr    = I_Valid & ~w_full;
    assign w_rd    = ~w_empty & I_Ready;
    assign w_count_next = w_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);

    // Storage is deliberately not reset; only pointers define contents.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp[AW-1:0]] <= I_Data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_ACCEPT: if (w_count_next >= C_HI) w_state_next = S_HOLD;
            S_HOLD:   if (w_count_next <= C_LO) w_state_next = S_ACCEPT;
            default:  w_state_next = S_ACCEPT;
        endcase
    end

    // Nack is registered from the next state so it tracks the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ACCEPT;
            r_nack  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_nack  <= (w_state_next == S_HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (I_Valid & w_full) begin
            r_ovf <= 1'b1;
        end else if (I_ClrErr) begin
            r_ovf <= 1'b0;
        end
    end

    assign O_Nack     = r_nack;
    assign O_Valid    = ~w_empty;
    assign O_Data     = r_mem[r_rp[AW-1:0]];
    assign O_Count    = w_count;
    assign O_Empty    = w_empty;
    assign O_Full     = w_full;
    assign O_Overflow = r_ovf;

endmodule

// File: tb/tb_retime_token_sink.sv
// Randomized and directed bench for retime_token_sink.
// A queue-based model tracks contents, Nack hysteresis and overflow.
module tb_retime_token_sink;

    localparam int DEPTH = 8;
    localparam int SLACK = 2;
    localparam int HI    = DEPTH - SLACK;
    localparam int LO    = HI - 2;

    logic        clk;
    logic        rst_n;
    logic        I_Valid;
    logic [31:0] I_Data;
    logic        O_Nack;
    logic        O_Valid;
    logic [31:0] O_Data;
    logic        I_Ready;
    logic [3:0]  O_Count;
    logic        O_Empty;
    logic        O_Full;
    logic        O_Overflow;
    logic        I_ClrErr;

    retime_token_sink #(
        .WIDTH_DATA(32),
        .DEPTH(DEPTH),
        .NACK_SLACK(SLACK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .I_Valid(I_Valid),
        .I_Data(I_Data),
        .O_Nack(O_Nack),
        .O_Valid(O_Valid),
        .O_Data(O_Data),
        .I_Ready(I_Ready),
        .O_Count(O_Count),
        .O_Empty(O_Empty),
        .O_Full(O_Full),
        .O_Overflow(O_Overflow),
        .I_ClrErr(I_ClrErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_q[$];
    bit          m_nack;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_nack = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_model();
        chk("valid", 64'(O_Valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk("data", 64'(O_Data), 64'(m_q[0]));
        chk("count", 64'(O_Count), 64'(m_q.size()));
        chk("empty", 64'(O_Empty), 64'(m_q.size() == 0));
        chk("full", 64'(O_Full), 64'(m_q.size() == DEPTH));
        chk("nack", 64'(O_Nack), 64'(m_nack));
        chk("ovf", 64'(O_Overflow), 64'(m_ovf));
    endtask

    task automatic model_step(input bit v, input logic [31:0] d,
                              input bit r, input bit c);
        bit full;
        int n;
        full = (m_q.size() == DEPTH);
        if (r && m_q.size() != 0) void'(m_q.pop_front());
        if (v && !full) m_q.push_back(d);
        if (v && full) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        n = m_q.size();
        if (!m_nack && n >= HI) m_nack = 1'b1;
        else if (m_nack && n <= LO) m_nack = 1'b0;
    endtask

    // Drive at negedge, compare against model, clock, then settle 1 unit.
    task automatic cyc(input bit v, input logic [31:0] d,
                       input bit r, input bit c);
        @(negedge clk);
        I_Valid  = v;
        I_Data   = d;
        I_Ready  = r;
        I_ClrErr = c;
        check_model();
        @(posedge clk);
        model_step(v, d, r, c);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(O_Valid), 64'(0));
        chk({tag, "_count"}, 64'(O_Count), 64'(0));
        chk({tag, "_empty"}, 64'(O_Empty), 64'(1));
        chk({tag, "_full"}, 64'(O_Full), 64'(0));
        chk({tag, "_nack"}, 64'(O_Nack), 64'(0));
        chk({tag, "_ovf"}, 64'(O_Overflow), 64'(0));
    endtask

    initial begin
        int pv;
        int pr;
        rst_n    = 1'b0;
        I_Valid  = 1'b0;
        I_Data   = '0;
        I_Ready  = 1'b0;
        I_ClrErr = 1'b0;
        model_reset();
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Three tokens held, then drained in order
        cyc(1, 32'hA, 0, 0);
        cyc(1, 32'hB, 0, 0);
        cyc(1, 32'hC, 0, 0);
        chk("t1_count", 64'(O_Count), 64'(3));
        chk("t1_nack", 64'(O_Nack), 64'(0));
        chk("t1_d0", 64'(O_Data), 64'hA);
        cyc(0, 0, 1, 0);
        chk("t1_d1", 64'(O_Data), 64'hB);
        cyc(0, 0, 1, 0);
        chk("t1_d2", 64'(O_Data), 64'hC);
        cyc(0, 0, 1, 0);
        chk("t1_empty", 64'(O_Empty), 64'(1));

        // Fill: Nack after 6th write, two slack entries absorbed
        for (int k = 1; k <= DEPTH; k++) begin
            cyc(1, $urandom, 0, 0);
            chk("t2_nack", 64'(O_Nack), 64'(k >= HI));
        end
        chk("t2_count", 64'(O_Count), 64'(8));
        chk("t2_full", 64'(O_Full), 64'(1));
        chk("t2_ovf", 64'(O_Overflow), 64'(0));

        // Overflow and clear
        cyc(1, 32'hDEAD, 0, 0);
        chk("t3_ovf", 64'(O_Overflow), 64'(1));
        chk("t3_count", 64'(O_Count), 64'(8));
        cyc(0, 0, 0, 1);
        chk("t3_clr", 64'(O_Overflow), 64'(0));

        // Drain: Nack holds at 7,6,5 and falls at 4
        for (int k = 7; k >= 0; k--) begin
            cyc(0, 0, 1, 0);
            chk("t4_count", 64'(O_Count), 64'(k));
            chk("t4_nack", 64'(O_Nack), 64'(k > LO));
        end

        // Streaming wrap: occupancy stays at 1
        for (int k = 0; k < 20; k++) begin
            cyc(1, 32'h100 + k, 1, 0);
            chk("t5_count", 64'(O_Count), 64'(1));
            chk("t5_nack", 64'(O_Nack), 64'(0));
            chk("t5_data", 64'(O_Data), 64'(32'h100 + k));
        end
        cyc(0, 0, 1, 0);

        // Full with simultaneous read and write
        for (int k = 0; k < DEPTH; k++) cyc(1, $urandom, 0, 0);
        cyc(1, 32'hBEEF, 1, 0);
        chk("t6_count", 64'(O_Count), 64'(7));
        chk("t6_ovf", 64'(O_Overflow), 64'(1));

        // Asynchronous reset mid-stream
        @(negedge clk);
        I_Valid = 1'b1;
        I_Ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        I_Valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized phases with varying pressure
        for (int s = 0; s < 30; s++) begin
            pv = $urandom_range(100);
            pr = $urandom_range(100);
            for (int k = 0; k < 60; k++) begin
                cyc($urandom_range(99) < pv, $urandom,
                    $urandom_range(99) < pr, $urandom_range(15) == 0);
            end
        end
        cyc(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/retime_token_sink.md
# retime_token_sink

Elastic receive buffer that sits directly downstream of a retiming token stage: it captures each Valid token and its data word into a FIFO, drains them to a consumer through a ready handshake, and returns a registered Nack token upstream. Nack uses hysteresis and reserves slack entries, so tokens already in flight when Nack rises are still absorbed. Any token arriving at a full buffer is an error; it is dropped and flagged with a sticky overflow.

## Interface
- WIDTH_DATA, 32, data word width
- DEPTH, 8, FIFO entries; power of two, >= 4
- NACK_SLACK, 2, entries reserved for in-flight tokens; 1 <= NACK_SLACK <= DEPTH-3
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0); all state clears immediately on assertion
- I_Valid  in  1  Valid token from upstream stage
- I_Data  in  WIDTH_DATA  data accompanying I_Valid
- O_Nack  out  1  Nack token to upstream (registered)
- O_Valid  out  1  head entry valid to consumer
- O_Data  out  WIDTH_DATA  head entry data
- I_Ready  in  1  consumer accepts head this cycle
- O_Count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- O_Empty  out  1  occupancy == 0
- O_Full  out  1  occupancy == DEPTH
- O_Overflow  out  1  sticky: token arrived while full
- I_ClrErr  in  1  synchronous clear of O_Overflow

## Operation
- Storage: DEPTH x WIDTH_DATA array, write pointer and read pointer of $clog2(DEPTH)+1 bits; MSB is wrap bit, index = low bits. Empty when pointers equal; full when low bits equal and MSBs differ.
- Write: I_Valid & ~O_Full (full sampled at start of cycle) -> mem[wp] <= I_Data, wp++.
- Read: O_Valid & I_Ready -> rp++. O_Valid = ~O_Empty; O_Data = mem[rp] (first-word fall-through from registered storage).
- Full with simultaneous read and write: write is rejected; there is no pass-through. Token is dropped and O_Overflow sets.
- Empty: there is no bypass. A written word appears on O_Data the next cycle.
- Count: count_next = count + wr - rd. Wrap-around is handled only by the pointer MSB.
- Nack FSM, two states. HI = DEPTH-NACK_SLACK; LO = HI-2.
  - sACCEPT: O_Nack=0. Go to sHOLD when count_next >= HI.
  - sHOLD: O_Nack=1. Go to sACCEPT when count_next <= LO.
  - O_Nack is a flop driven from the next state, so it reflects the state entered at the same edge.
- Upstream keeps presenting I_Valid under Nack (stall) and resends after Nack falls. The sink does not dedupe. Each accepted cycle with I_Valid=1 is one entry.
- O_Overflow: set on I_Valid & O_Full. Clear on I_ClrErr. Set wins over clear in the same cycle.
- Reset: wp=rp=0, count=0, state sACCEPT, O_Nack=0, O_Valid=0, O_Empty=1, O_Full=0, O_Overflow=0, O_Count=0. O_Data is don't-care (array not reset). A reset mid-stream discards all contents.

## Timing
- Write-to-output latency: 1 cycle (I_Valid at edge n -> O_Valid high after edge n).
- Read takes effect at the edge where O_Valid & I_Ready; the next entry is visible after that edge.
- Nack rises at the same edge that makes occupancy reach HI. Upstream sees it one cycle later.
- Up to NACK_SLACK further tokens after Nack rises must be absorbed without overflow.
- Nack falls at the edge occupancy drops to <= LO.
- Every output is a flop or a direct decode of flops. There is no combinational path from I_Valid or I_Ready to O_Nack.

## Test plan
- Reset, then 3 tokens (data 0xA,0xB,0xC) with I_Ready=0 -> O_Count=3, O_Nack=0; raise I_Ready -> O_Data sequence 0xA,0xB,0xC on consecutive cycles, then O_Empty=1.
- DEPTH=8, NACK_SLACK=2, I_Ready=0, continuous I_Valid -> O_Nack=1 after the 6th write. Two more tokens accepted (O_Count=8, O_Full=1), O_Overflow=0.
- From full, one more I_Valid -> data dropped, O_Overflow=1, O_Count stays 8. I_ClrErr pulse -> O_Overflow=0.
- From count 8 with Nack high, I_Ready=1 and I_Valid=0 -> Nack stays 1 at counts 7,6,5 and falls at the edge count reaches 4.
- Wrap: 20 tokens with I_Valid and I_Ready both high every cycle -> O_Count constant 1, output data in order, pointers wrap twice, O_Nack stays 0.
- Full, simultaneous I_Valid & I_Ready -> read occurs, write rejected, O_Overflow=1, O_Count=7. Then assert reset mid-stream -> all outputs at reset values asynchronously.
